// File: rtl/conv_pkg.sv
// Constants and helpers shared by the 3x3 window generator and the conv3x3_sum consumer.
package conv_pkg;

    localparam int K     = 3;
    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    // Flat element position inside a window: channel-major, then row, then column.
    function automatic int win_idx(input int c, input int r, input int k);
        return c * K * K + r * K + k;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Two chained row buffers addressed by column: row1 holds image row y-1, row2 holds row y-2.
module conv_line_buf #(
    parameter int PIXW  = 64,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [PIXW-1:0] wdata_i,
    output logic [PIXW-1:0] row1_o,
    output logic [PIXW-1:0] row2_o
);

    logic [PIXW-1:0] row1_mem [DEPTH];
    logic [PIXW-1:0] row2_mem [DEPTH];

    // Same-cycle read so a frame-start pixel can redirect the address to column 0.
    assign row1_o = row1_mem[addr_i];
    assign row2_o = row2_mem[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            row2_mem[addr_i] <= row1_mem[addr_i];
            row1_mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv_win_gen.sv
// Streaming 3x3 window generator: raster-order pixels in, one KxKxIFM_CH window per
// valid (no padding, stride 1) output position out, with a ready/valid output register.
module conv_win_gen
    import conv_pkg::*;
#(
    parameter int DATAW  = 8,
    parameter int IFM_CH = 8,
    parameter int K      = 3,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_vld,
    output logic                          pix_rdy,
    input  logic                          pix_sof,
    input  logic [DATAW*IFM_CH-1:0]       pix_data,
    output logic                          win_vld,
    input  logic                          win_rdy,
    output logic [DATAW*IFM_CH*K*K-1:0]   win_data,
    output logic                          win_last
);

    localparam int PIXW  = DATAW * IFM_CH;
    localparam int WINW  = PIXW * K * K;
    localparam int LB_AW = $clog2(IMG_W);

    cnt_t x_q, y_q, x_d, y_d, cx, cy;
    logic acc, emit, last_pos;

    logic [PIXW-1:0] row1, row2;
    logic [PIXW-1:0] sr_q [K][K];
    logic [PIXW-1:0] sr_d [K][K];

    logic            win_vld_q, win_last_q;
    logic [WINW-1:0] win_data_q, win_data_d;

    assign pix_rdy  = !win_vld_q || win_rdy;
    assign acc      = pix_vld && pix_rdy;
    assign win_vld  = win_vld_q;
    assign win_data = win_data_q;
    assign win_last = win_last_q;

    // A frame-start pixel overrides the counters and is placed at (0,0).
    always_comb begin
        cx       = pix_sof ? '0 : x_q;
        cy       = pix_sof ? '0 : y_q;
        emit     = acc && (cx >= cnt_t'(2)) && (cy >= cnt_t'(2));
        last_pos = (cx == cnt_t'(IMG_W - 1)) && (cy == cnt_t'(IMG_H - 1));
        if (cx == cnt_t'(IMG_W - 1)) begin
            x_d = '0;
            y_d = (cy == cnt_t'(IMG_H - 1)) ? '0 : cy + cnt_t'(1);
        end else begin
            x_d = cx + cnt_t'(1);
            y_d = cy;
        end
    end

    conv_line_buf #(
        .PIXW  (PIXW),
        .DEPTH (IMG_W),
        .AW    (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (acc),
        .addr_i  (cx[LB_AW-1:0]),
        .wdata_i (pix_data),
        .row1_o  (row1),
        .row2_o  (row2)
    );

    genvar gi, gr, gk, gc;

    // Shift-register next state: older columns move left, the new right column enters.
    generate
        for (gr = 0; gr < K; gr++) begin : g_row
            for (gk = 0; gk < K - 1; gk++) begin : g_shift
                assign sr_d[gr][gk] = sr_q[gr][gk+1];
            end
        end
    endgenerate

    assign sr_d[0][K-1] = row2;
    assign sr_d[1][K-1] = row1;
    assign sr_d[2][K-1] = pix_data;

    // The emitted window is taken from the post-shift contents so it includes the new pixel.
    generate
        for (gc = 0; gc < IFM_CH; gc++) begin : g_ch
            for (gr = 0; gr < K; gr++) begin : g_r
                for (gi = 0; gi < K; gi++) begin : g_k
                    localparam int IDX = win_idx(gc, gr, gi);
                    assign win_data_d[IDX*DATAW +: DATAW] = sr_d[gr][gi][gc*DATAW +: DATAW];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
            win_data_q <= '0;
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K; k++) begin
                    sr_q[r][k] <= '0;
                end
            end
        end else begin
            if (acc) begin
                x_q <= x_d;
                y_q <= y_d;
                for (int r = 0; r < K; r++) begin
                    for (int k = 0; k < K; k++) begin
                        sr_q[r][k] <= sr_d[r][k];
                    end
                end
            end
            if (emit) begin
                win_vld_q  <= 1'b1;
                win_data_q <= win_data_d;
                win_last_q <= last_pos;
            end else if (win_rdy) begin
                win_vld_q  <= 1'b0;
                win_last_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_win_gen.sv
// Bench for conv_win_gen: two instances (2 and 8 channels) on a 5x4 image share one
// handshake; a position/image model predicts every output cycle.
`timescale 1ns/1ps
module tb_conv_win_gen;

    localparam int DW  = 8;
    localparam int W   = 5;
    localparam int H   = 4;
    localparam int CA  = 2;
    localparam int CB  = 8;
    localparam int PWA = DW * CA;
    localparam int PWB = DW * CB;
    localparam int WWA = PWA * 9;
    localparam int WWB = PWB * 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           pix_vld = 1'b0;
    logic           pix_sof = 1'b0;
    logic           win_rdy = 1'b1;
    logic [PWA-1:0] pix_data_a = '0;
    logic [PWB-1:0] pix_data_b = '0;
    logic           pix_rdy_a, pix_rdy_b, win_vld_a, win_vld_b, win_last_a, win_last_b;
    logic [WWA-1:0] win_data_a;
    logic [WWB-1:0] win_data_b;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    conv_win_gen #(.DATAW(DW), .IFM_CH(CA), .K(3), .IMG_W(W), .IMG_H(H)) dut_a (
        .clk(clk), .rst(rst), .pix_vld(pix_vld), .pix_rdy(pix_rdy_a), .pix_sof(pix_sof),
        .pix_data(pix_data_a), .win_vld(win_vld_a), .win_rdy(win_rdy),
        .win_data(win_data_a), .win_last(win_last_a));

    conv_win_gen #(.DATAW(DW), .IFM_CH(CB), .K(3), .IMG_W(W), .IMG_H(H)) dut_b (
        .clk(clk), .rst(rst), .pix_vld(pix_vld), .pix_rdy(pix_rdy_b), .pix_sof(pix_sof),
        .pix_data(pix_data_b), .win_vld(win_vld_b), .win_rdy(win_rdy),
        .win_data(win_data_b), .win_last(win_last_b));

    task automatic chk_bit(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [WWB-1:0] got, input logic [WWB-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // ---------------- model: image store indexed by pixel position ----------------
    logic [PWA-1:0] img_a [H][W];
    logic [PWB-1:0] img_b [H][W];
    logic           m_vld  = 1'b0;
    logic           m_last = 1'b0;
    logic [WWA-1:0] m_a    = '0;
    logic [WWB-1:0] m_b    = '0;
    int             mx = 0, my = 0;

    task automatic build_window(input int px, input int py);
        logic [PWA-1:0] pa;
        logic [PWB-1:0] pb;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                pa = img_a[py-2+r][px-2+k];
                pb = img_b[py-2+r][px-2+k];
                for (int c = 0; c < CA; c++) m_a[(c*9 + r*3 + k)*DW +: DW] = pa[c*DW +: DW];
                for (int c = 0; c < CB; c++) m_b[(c*9 + r*3 + k)*DW +: DW] = pb[c*DW +: DW];
            end
        end
    endtask

    task automatic model_step();
        bit acc, hs;
        int px, py;
        hs  = m_vld && win_rdy;
        acc = pix_vld && (!m_vld || win_rdy);
        if (hs) m_vld = 1'b0;
        if (acc) begin
            px = pix_sof ? 0 : mx;
            py = pix_sof ? 0 : my;
            img_a[py][px] = pix_data_a;
            img_b[py][px] = pix_data_b;
            if (px >= 2 && py >= 2) begin
                m_vld  = 1'b1;
                m_last = (px == W - 1) && (py == H - 1);
                build_window(px, py);
            end
            mx = px + 1;
            my = py;
            if (mx == W) begin
                mx = 0;
                my = (py + 1 == H) ? 0 : py + 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_vld  = 1'b0;
                m_last = 1'b0;
                mx     = 0;
                my     = 0;
            end else begin
                model_step();
            end
        end
    end

    // ---------------- per-cycle compare and handoff log ----------------
    logic [WWA-1:0] got_a [$];
    logic           got_la [$];
    logic [WWB-1:0] got_b [$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk_bit("rdy_a", pix_rdy_a, !m_vld || win_rdy);
                chk_bit("rdy_b", pix_rdy_b, !m_vld || win_rdy);
                chk_bit("vld_a", win_vld_a, m_vld);
                chk_bit("vld_b", win_vld_b, m_vld);
                if (m_vld) begin
                    chk_vec("data_a", WWB'(win_data_a), WWB'(m_a));
                    chk_vec("data_b", win_data_b, m_b);
                    chk_bit("last_a", win_last_a, m_last);
                    chk_bit("last_b", win_last_b, m_last);
                end
                if (win_vld_a && win_rdy) begin
                    got_a.push_back(win_data_a);
                    got_la.push_back(win_last_a);
                end
                if (win_vld_b && win_rdy) got_b.push_back(win_data_b);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [PWA-1:0] mk_a(input int x, input int y);
        logic [PWA-1:0] v;
        for (int c = 0; c < CA; c++) v[c*DW +: DW] = DW'(16*y + x + 128*c);
        return v;
    endfunction

    function automatic logic [PWB-1:0] mk_b(input int x, input int y);
        logic [PWB-1:0] v;
        for (int c = 0; c < CB; c++) v[c*DW +: DW] = DW'(64*y + 8*x + c);
        return v;
    endfunction

    function automatic logic [WWA-1:0] get_a(input int i);
        return (got_a.size() > i) ? got_a[i] : '0;
    endfunction

    function automatic logic [WWB-1:0] get_b(input int i);
        return (got_b.size() > i) ? got_b[i] : '0;
    endfunction

    function automatic int sum_b(input logic [WWB-1:0] w);
        int s = 0;
        for (int i = 0; i < CB*9; i++) s += int'(w[i*DW +: DW]);
        return s;
    endfunction

    task automatic send_pix(input int x, input int y, input bit sof);
        int n = 0;
        pix_vld    = 1'b1;
        pix_sof    = sof;
        pix_data_a = mk_a(x, y);
        pix_data_b = mk_b(x, y);
        forever begin
            @(negedge clk);
            if (pix_rdy_a === 1'b1) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: pixel (%0d,%0d) not accepted within 50 cycles", x, y);
                break;
            end
        end
        @(posedge clk);
        #1;
        pix_vld = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic send_idx(input int i, input bit sof);
        send_pix(i % W, i / W, sof);
    endtask

    task automatic send_frame(input bit sof_first);
        for (int i = 0; i < W*H; i++) send_idx(i, sof_first && (i == 0));
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_a.delete();
        got_la.delete();
        got_b.delete();
    endtask

    logic [WWA-1:0] ref_a [6];
    logic [WWA-1:0] snap;
    longint         t0;
    int             nlast;

    task automatic check_frame_vs_ref(input string name, input int base);
        for (int i = 0; i < 6; i++) chk_vec(name, WWB'(get_a(base + i)), WWB'(ref_a[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset_vld", win_vld_a, 1'b0);
        chk_bit("reset_last", win_last_a, 1'b0);
        chk_vec("reset_data", WWB'(win_data_a), '0);
        chk_bit("reset_rdy", pix_rdy_a, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame fill
        clear_logs();
        t0 = cyc;
        send_frame(1'b1);
        chk_int("fill_cycles", int'(cyc - t0), 20);
        settle();
        chk_int("fill_count", got_a.size(), 6);
        chk_int("fill_e00_c0", int'(get_a(0)[0 +: 8]), 8'h00);
        chk_int("fill_e22_c0", int'(get_a(0)[8*8 +: 8]), 8'h22);
        chk_int("fill_e00_c1", int'(get_a(0)[9*8 +: 8]), 8'h80);
        chk_int("fill_lastwin_e22_c0", int'(get_a(5)[8*8 +: 8]), 8'h34);
        nlast = 0;
        foreach (got_la[i]) nlast += int'(got_la[i]);
        chk_int("fill_last_count", nlast, 1);
        chk_bit("fill_last_pos", (got_la.size() > 5) ? got_la[5] : 1'b0, 1'b1);
        chk_int("chan_sum_first", sum_b(get_b(0)), 5436);
        chk_int("chan_sum_last", sum_b(get_b(5)), 11196);
        chk_int("chan_c5r1k2", int'(get_b(0)[50*8 +: 8]), 85);
        chk_int("chan_c7r2k0", int'(get_b(5)[69*8 +: 8]), 215);
        for (int i = 0; i < 6; i++) ref_a[i] = get_a(i);
        $display("frame fill: %0d windows", got_a.size());

        // Multi-frame
        clear_logs();
        send_frame(1'b1);
        send_frame(1'b1);
        settle();
        chk_int("multi_count", got_a.size(), 12);
        check_frame_vs_ref("multi_f1", 0);
        check_frame_vs_ref("multi_f2", 6);
        $display("multi frame: %0d windows", got_a.size());

        // Backpressure on window (3,2)
        clear_logs();
        for (int i = 0; i <= 13; i++) send_idx(i, i == 0);
        win_rdy = 1'b0;
        snap    = win_data_a;
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                chk_bit("bp_rdy_low", pix_rdy_a, 1'b0);
                chk_bit("bp_vld_held", win_vld_a, 1'b1);
                chk_vec("bp_data_held", WWB'(win_data_a), WWB'(snap));
                win_rdy = 1'b1;
            end
            begin
                for (int i = 14; i < W*H; i++) send_idx(i, 1'b0);
            end
        join
        settle();
        chk_int("bp_count", got_a.size(), 6);
        check_frame_vs_ref("bp_win", 0);
        $display("backpressure: %0d windows", got_a.size());

        // Resync at pixel index 7
        clear_logs();
        for (int i = 0; i < 7; i++) send_idx(i, i == 0);
        for (int i = 0; i < 12; i++) send_idx(i, i == 0);
        settle();
        chk_int("resync_none_yet", got_a.size(), 0);
        send_idx(12, 1'b0);
        settle();
        chk_int("resync_first", got_a.size(), 1);
        for (int i = 13; i < W*H; i++) send_idx(i, 1'b0);
        settle();
        chk_int("resync_count", got_a.size(), 6);
        check_frame_vs_ref("resync_win", 0);
        $display("resync: %0d windows", got_a.size());

        // Reset mid-frame
        clear_logs();
        for (int i = 0; i <= 12; i++) send_idx(i, i == 0);
        chk_bit("pre_reset_vld", win_vld_a, 1'b1);
        rst = 1'b1;
        #1;
        chk_bit("async_reset_vld", win_vld_a, 1'b0);
        chk_bit("async_reset_rdy", pix_rdy_a, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        send_frame(1'b0);
        settle();
        chk_int("post_reset_count", got_a.size(), 6);
        check_frame_vs_ref("post_reset_win", 0);
        $display("reset mid-frame: %0d windows", got_a.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_win_gen.md
# conv_win_gen

Streaming 3x3 window generator that feeds the conv3x3_sum datapath. It accepts one multi-channel pixel per handshake in raster order and buffers two previous image rows. It emits one K×K×IFM_CH window per valid output position (no padding, stride 1), in exactly the flat layout the convolution sum consumes on `win_data`/`in_vld`.

## Interface
Parameters:
- DATAW, 8: bits per channel sample
- IFM_CH, 8: channels per pixel
- K, 3: window size; only 3 supported
- IMG_W, 32: image width in pixels, ≥ 3, ≤ 1024
- IMG_H, 32: image height in pixels, ≥ 3, ≤ 1024

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- pix_vld  in  1  input pixel valid
- pix_rdy  out  1  input ready; pixel accepted when pix_vld && pix_rdy
- pix_sof  in  1  start of frame; qualifies accepted pixel as (x=0, y=0)
- pix_data  in  DATAW*IFM_CH  one pixel; channel c at [c*DATAW +: DATAW]
- win_vld  out  1  window valid (drives consumer in_vld)
- win_rdy  in  1  downstream ready; tie high for conv3x3_sum
- win_data  out  DATAW*IFM_CH*K*K  window; element i = c*9 + r*3 + k at [i*DATAW +: DATAW]
- win_last  out  1  qualifies last window of the frame

## Operation
- Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) advance on each accepted pixel; x wraps to 0 and increments y; at (IMG_W-1, IMG_H-1) both wrap to 0.
- An accepted pixel with pix_sof=1 is treated as (0,0) regardless of the counters, and counters continue from (1,0). pix_sof at (0,0) is a no-op resync.
- Two line buffers of IMG_W pixels hold rows y-1 and y-2. On acceptance at column x:
  - read both buffers at x;
  - write row y-1's value into the y-2 buffer and the new pixel into the y-1 buffer.
- A 3×3 pixel shift register shifts left one column per accepted pixel; the new right column is (row y-2, row y-1, new pixel).
- Window element (r,k) = pixel(y-2+r, x-2+k): r=0 is the top row, k=0 the left column, channel-major across elements.
- A window is emitted only when x≥2 and y≥2, giving (IMG_W-2)*(IMG_H-2) windows per frame. Stale columns at x<2 are never emitted.
- win_last=1 only with the window at (IMG_W-1, IMG_H-1).
- Output register: win_vld/win_data/win_last stay stable while win_vld && !win_rdy.
- pix_rdy = !win_vld || win_rdy (combinational). Accepting a non-emitting pixel while a window is pending is not allowed; pix_rdy stays low until the window is taken.
- Line-buffer contents are not cleared by reset or frame start. Rows 0/1 rewrite them before any window uses them.

## Timing
- Reset values: win_vld=0, win_last=0, win_data=0, x=y=0, shift register 0. pix_rdy=1 while in reset.
- Latency: accepted emitting pixel at edge n → win_vld=1 after edge n, i.e. visible in cycle n+1.
- Throughput: one pixel and one window per cycle when win_rdy=1 continuously.
- A window handed off (win_vld && win_rdy) in the same cycle a new emitting pixel is accepted is replaced back-to-back; win_vld stays 1.
- Line-buffer read is same-cycle or registered as the implementation chooses. The 1-cycle output latency is fixed either way.
- Reset asserted mid-frame: win_vld drops immediately (async) and counters return to (0,0). The next pixel is treated as frame start.

## Structure
- Shared package conv_pkg: K=3, the window element index function c*K*K + r*K + k, and counter width clog2(1024)=10. This package is also used by the conv3x3_sum consumer.
- Sub-module conv_line_buf: two IMG_W × (DATAW*IFM_CH) buffers, one write and two reads per accepted pixel, with address = x.
- Top level holds the counters, the shift register, and the output register/handshake.

## Test plan
- Frame fill: IMG_W=5, IMG_H=4, IFM_CH=2, channel-c sample of pixel (x,y) = 16*y + x + 128*c, win_rdy=1, 20 back-to-back pixels → exactly 6 windows. First window one cycle after pixel (2,2) with ch0 element(0,0)=0x00 and element(2,2)=0x22. win_last only on window (4,3).
- Multi-frame: two consecutive 5×4 frames with pix_sof on each first pixel → 12 windows total; second-frame contents identical to the first.
- Backpressure: win_rdy low for 5 cycles while window (3,2) is pending → win_data/win_vld held unchanged and pix_rdy=0. Release → next window follows with no pixel lost.
- Resync: pix_sof asserted at pixel index 7 of a frame → counting restarts, and the first window appears after 12 further pixels.
- Reset mid-frame: assert rst after 13 pixels with win_vld=1 → win_vld=0 immediately. A subsequent full frame yields the correct 6 windows.
- Channel layout: IFM_CH=8, pixel channels = distinct constants → element index c*9 + r*3 + k matches the bit slice consumed by conv3x3_sum. End-to-end sum checked against a software model.
